// File: rtl/wave_gen_pkg.sv
// wave_gen_pkg: shared types and reset defaults for the wave_gen block.
// Holds the FSM state enum, the waveform config struct {period, rise, fall}
// and the constants loaded into the active config at reset.
// The struct field width is WG_CNT_W; wave_gen's CNT_W must match it.
package wave_gen_pkg;

  localparam int WG_CNT_W      = 8;
  localparam int WG_DEF_PERIOD = 10;
  localparam int WG_DEF_RISE   = 0;
  localparam int WG_DEF_FALL   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } wave_state_e;

  typedef struct packed {
    logic [WG_CNT_W-1:0] period;
    logic [WG_CNT_W-1:0] rise;
    logic [WG_CNT_W-1:0] fall;
  } wave_cfg_t;

endpackage

// File: rtl/wave_cfg_check.sv
// wave_cfg_check: combinational sanity check of a waveform configuration.
// Ports:
//   cfg - candidate {period, rise, fall}
//   ok  - 1 when period >= 2, rise < fall and fall <= period (all unsigned)
module wave_cfg_check
  import wave_gen_pkg::*;
(
  input  wave_cfg_t cfg,
  output logic      ok
);

  // A waveform needs at least two phases and a non-empty high window that
  // fits inside the period.
  assign ok = (cfg.period >= WG_CNT_W'(2)) &&
              (cfg.rise < cfg.fall) &&
              (cfg.fall <= cfg.period);

endmodule

// File: rtl/wave_gen.sv
// wave_gen: programmable periodic waveform generator driven from clk.
// A phase counter runs 0..period-1; wave_out is high while rise <= ph < fall.
// New configurations are accepted in IDLE or on the last phase of a period,
// so a change always lands cleanly on a period boundary.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   run                 - level request for waveform generation
//   cfg_valid/cfg_ready - config offer handshake
//   cfg_period/rise/fall- offered config
//   wave_out            - registered waveform
//   rise_stb, fall_stb  - one-cycle edge pulses of wave_out
//   period_stb          - pulse on phase 0 while running
//   cfg_err             - sticky flag for a rejected config
//   cyc_cnt             - completed-period counter (only with WAVE_GEN_CYC_CNT_EN)
// Optional feature macro: WAVE_GEN_CYC_CNT_EN
module wave_gen
  import wave_gen_pkg::*;
#(
  parameter int CNT_W      = WG_CNT_W,
  parameter int DEF_PERIOD = WG_DEF_PERIOD,
  parameter int DEF_RISE   = WG_DEF_RISE,
  parameter int DEF_FALL   = WG_DEF_FALL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_rise,
  input  logic [CNT_W-1:0] cfg_fall,
  output logic             wave_out,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             period_stb,
`ifdef WAVE_GEN_CYC_CNT_EN
  output logic [15:0]      cyc_cnt,
`endif
  output logic             cfg_err
);

  wave_state_e      state_q, state_d;
  logic [CNT_W-1:0] ph_q, ph_d;
  wave_cfg_t        activeCfg_q, offeredCfg, effCfg;
  logic             wave_q, wave_d;
  logic             prevWave_q;
  logic             cfgErr_q, cfgErr_d;
  logic             offerOk, cfgTake, atLast;

  assign offeredCfg = '{period: cfg_period, rise: cfg_rise, fall: cfg_fall};

  wave_cfg_check uCfgCheck (
    .cfg (offeredCfg),
    .ok  (offerOk)
  );

  // Last phase of the current period, judged against the active (old) period.
  assign atLast    = (ph_q == activeCfg_q.period - CNT_W'(1));
  assign cfg_ready = (state_q == IDLE) || atLast;
  assign cfgTake   = cfg_valid && cfg_ready;

  // The config in force for the next phase: a freshly accepted valid offer
  // applies immediately, which is what lets a config offered together with
  // a run start shape the very first period.
  assign effCfg   = (cfgTake && offerOk) ? offeredCfg : activeCfg_q;
  assign cfgErr_d = cfgTake ? ~offerOk : cfgErr_q;

  // Next-state, next-phase and next-waveform logic. The waveform is derived
  // from ph_d so that wave_out and ph change on the same edge.
  always_comb begin
    state_d = state_q;
    ph_d    = '0;
    wave_d  = 1'b0;
    unique case (state_q)
      IDLE:    if (run) state_d = RUN;
      RUN:     if (!run) state_d = atLast ? IDLE : DRAIN;
      DRAIN: begin
        if (run)         state_d = RUN;
        else if (atLast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && state_d != IDLE) begin
      ph_d = atLast ? '0 : ph_q + CNT_W'(1);
    end
    if (state_d != IDLE) begin
      wave_d = (effCfg.rise <= ph_d) && (ph_d < effCfg.fall);
    end
  end

  // Main state registers; reset restores the default waveform.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ph_q        <= '0;
      activeCfg_q <= '{period: CNT_W'(DEF_PERIOD),
                       rise:   CNT_W'(DEF_RISE),
                       fall:   CNT_W'(DEF_FALL)};
      wave_q      <= 1'b0;
      prevWave_q  <= 1'b0;
      cfgErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      activeCfg_q <= effCfg;
      wave_q      <= wave_d;
      prevWave_q  <= wave_q;
      cfgErr_q    <= cfgErr_d;
    end
  end

  assign wave_out   = wave_q;
  assign rise_stb   = wave_q & ~prevWave_q;
  assign fall_stb   = ~wave_q & prevWave_q;
  assign period_stb = (state_q == RUN) && (ph_q == '0);
  assign cfg_err    = cfgErr_q;

`ifdef WAVE_GEN_CYC_CNT_EN
  logic [15:0] cycCnt_q;
  logic        seenStart_q;

  // The first period_stb of a run only marks the start; every later one
  // closes a full period. DRAIN->RUN stays within the same run, so only
  // IDLE forgets that the start was seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycCnt_q    <= '0;
      seenStart_q <= 1'b0;
    end else if (period_stb) begin
      if (seenStart_q) cycCnt_q <= cycCnt_q + 16'd1;
      seenStart_q <= 1'b1;
    end else if (state_q == IDLE) begin
      seenStart_q <= 1'b0;
    end
  end

  assign cyc_cnt = cycCnt_q;
`else
  // Without the counter there is no run-start bookkeeping to keep.
`endif

endmodule

// File: tb/tb_wave_gen.sv
// tb_wave_gen: directed self-checking bench for wave_gen with default
// parameters. Expected waveforms are written out by hand per scenario;
// strobe expectations follow from the expected waveform sequence.
module tb_wave_gen;

  logic       clk;
  logic       rst;
  logic       run;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_period;
  logic [7:0] cfg_rise;
  logic [7:0] cfg_fall;
  logic       wave_out;
  logic       rise_stb;
  logic       fall_stb;
  logic       period_stb;
  logic       cfg_err;
`ifdef WAVE_GEN_CYC_CNT_EN
  logic [15:0] cyc_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic expPrevWave = 1'b0;

  wave_gen dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_rise   (cfg_rise),
    .cfg_fall   (cfg_fall),
    .wave_out   (wave_out),
    .rise_stb   (rise_stb),
    .fall_stb   (fall_stb),
    .period_stb (period_stb),
`ifdef WAVE_GEN_CYC_CNT_EN
    .cyc_cnt    (cyc_cnt),
`endif
    .cfg_err    (cfg_err)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Checks wave_out and period_stb against hand-computed values; the
  // strobes follow from this and the previously expected waveform level.
  task automatic checkWave(input string tag, input logic expWave,
                           input logic expPer);
    checkOutput({tag, " wave"}, wave_out, expWave);
    checkOutput({tag, " rise"}, rise_stb, expWave & ~expPrevWave);
    checkOutput({tag, " fall"}, fall_stb, ~expWave & expPrevWave);
    checkOutput({tag, " period"}, period_stb, expPer);
    expPrevWave = expWave;
  endtask

  task automatic applyStimulus(input logic r, input logic v,
                               input logic [7:0] p, input logic [7:0] rs,
                               input logic [7:0] f);
    run        = r;
    cfg_valid  = v;
    cfg_period = p;
    cfg_rise   = rs;
    cfg_fall   = f;
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 8'd0, 8'd0, 8'd0);
    step();
    step();
    // Reset state
    checkWave("reset", 0, 0);
    checkOutput("reset ready", cfg_ready, 1);
    checkOutput("reset err", cfg_err, 0);
`ifdef WAVE_GEN_CYC_CNT_EN
    checkOutput("reset cyc", cyc_cnt, 0);
`endif
    rst = 1'b0;
    step();
    checkWave("idle", 0, 0);

    // Defaults {10,0,5} with run held: 5 high, 5 low
    applyStimulus(1, 0, 8'd0, 8'd0, 8'd0);
    for (int k = 0; k < 20; k++) begin
      step();
      checkWave($sformatf("def k%0d", k), (k % 10) < 5, (k % 10) == 0);
      checkOutput($sformatf("def ready k%0d", k), cfg_ready, (k % 10) == 9);
    end
`ifdef WAVE_GEN_CYC_CNT_EN
    checkOutput("def cyc", cyc_cnt, 1);
`endif
    // Stop at the last phase: straight to IDLE
    applyStimulus(0, 0, 8'd0, 8'd0, 8'd0);
    step();
    checkWave("stop", 0, 0);
    checkOutput("stop ready", cfg_ready, 1);

    // Config {6,2,5} offered with the run start: 0,0,1,1,1,0
    applyStimulus(1, 1, 8'd6, 8'd2, 8'd5);
    for (int k = 0; k < 12; k++) begin
      step();
      checkWave($sformatf("c625 k%0d", k), (k % 6) >= 2 && (k % 6) < 5,
                (k % 6) == 0);
      checkOutput($sformatf("c625 ready k%0d", k), cfg_ready, (k % 6) == 5);
      applyStimulus(1, 0, 8'd6, 8'd2, 8'd5);
    end
    checkOutput("c625 err", cfg_err, 0);

    // Invalid {4,3,3} at ph 5: discarded, err set, pattern unchanged
    applyStimulus(1, 1, 8'd4, 8'd3, 8'd3);
    for (int k = 0; k < 6; k++) begin
      step();
      checkWave($sformatf("bad k%0d", k), k >= 2 && k < 5, k == 0);
      checkOutput($sformatf("bad err k%0d", k), cfg_err, 1);
      applyStimulus(1, 0, 8'd4, 8'd3, 8'd3);
    end

    // Valid {8,0,4} clears err
    applyStimulus(1, 1, 8'd8, 8'd0, 8'd4);
    for (int k = 0; k < 8; k++) begin
      step();
      checkWave($sformatf("c804 k%0d", k), k < 4, k == 0);
      checkOutput($sformatf("c804 err k%0d", k), cfg_err, 0);
      applyStimulus(1, 0, 8'd8, 8'd0, 8'd4);
    end

    // Back to period 10, then hold {4,1,3} from ph 2: ready only at ph 9
    applyStimulus(1, 1, 8'd10, 8'd0, 8'd5);
    for (int k = 0; k < 3; k++) begin
      step();
      checkWave($sformatf("c1005 k%0d", k), k < 5, k == 0);
      applyStimulus(1, 0, 8'd10, 8'd0, 8'd5);
    end
    checkOutput("hold ready ph2", cfg_ready, 0);
    applyStimulus(1, 1, 8'd4, 8'd1, 8'd3);
    for (int k = 3; k < 10; k++) begin
      step();
      checkWave($sformatf("hold k%0d", k), k < 5, 0);
      checkOutput($sformatf("hold ready k%0d", k), cfg_ready, k == 9);
    end
    step();
    checkWave("c413 k0", 0, 1);
    checkOutput("c413 ready k0", cfg_ready, 0);
    applyStimulus(1, 0, 8'd4, 8'd1, 8'd3);
    for (int k = 1; k < 8; k++) begin
      step();
      checkWave($sformatf("c413 k%0d", k), (k % 4) == 1 || (k % 4) == 2,
                (k % 4) == 0);
    end

    // {10,1,6}, drop run at ph 3: drain ph 4..9 then IDLE
    applyStimulus(1, 1, 8'd10, 8'd1, 8'd6);
    for (int k = 0; k < 4; k++) begin
      step();
      checkWave($sformatf("c1016 k%0d", k), k >= 1 && k < 6, k == 0);
      applyStimulus((k == 3) ? 1'b0 : 1'b1, 0, 8'd10, 8'd1, 8'd6);
    end
    for (int k = 4; k < 10; k++) begin
      step();
      checkWave($sformatf("drain k%0d", k), k < 6, 0);
      checkOutput($sformatf("drain ready k%0d", k), cfg_ready, k == 9);
    end
    step();
    checkWave("drain idle", 0, 0);
    checkOutput("drain idle ready", cfg_ready, 1);

    // Drop at ph 3, re-raise at ph 6: no gap, period_stb again at ph 0
    applyStimulus(1, 0, 8'd10, 8'd1, 8'd6);
    for (int k = 0; k < 13; k++) begin
      step();
      checkWave($sformatf("regain k%0d", k),
                (k % 10) >= 1 && (k % 10) < 6, (k % 10) == 0);
      applyStimulus((k >= 3 && k <= 5) ? 1'b0 : 1'b1, 0, 8'd10, 8'd1, 8'd6);
    end

    // Reset at ph 2: everything back to reset values next cycle
    rst = 1'b1;
    step();
    expPrevWave = 1'b0;
    checkWave("rst mid", 0, 0);
    checkOutput("rst mid ready", cfg_ready, 1);
    checkOutput("rst mid err", cfg_err, 0);
`ifdef WAVE_GEN_CYC_CNT_EN
    checkOutput("rst mid cyc", cyc_cnt, 0);
`endif
    rst = 1'b0;
    applyStimulus(1, 0, 8'd0, 8'd0, 8'd0);
    for (int k = 0; k < 10; k++) begin
      step();
      checkWave($sformatf("post rst k%0d", k), k < 5, k == 0);
      if (k == 9) applyStimulus(0, 0, 8'd0, 8'd0, 8'd0);
    end
    step();
    checkWave("post rst idle", 0, 0);

    // {4,0,4}: always high, rise only at start, fall only at stop
    applyStimulus(1, 1, 8'd4, 8'd0, 8'd4);
    for (int k = 0; k < 8; k++) begin
      step();
      checkWave($sformatf("full k%0d", k), 1, (k % 4) == 0);
      applyStimulus((k == 7) ? 1'b0 : 1'b1, 0, 8'd4, 8'd0, 8'd4);
    end
    step();
    checkWave("full stop", 0, 0);
    step();
    checkWave("full idle", 0, 0);

    // Boundary configs in IDLE
    applyStimulus(0, 1, 8'd1, 8'd0, 8'd1);
    step();
    checkOutput("period1 err", cfg_err, 1);
    applyStimulus(0, 1, 8'd6, 8'd0, 8'd3);
    step();
    checkOutput("c603 err", cfg_err, 0);
    applyStimulus(0, 1, 8'd5, 8'd0, 8'd6);
    step();
    checkOutput("fall>period err", cfg_err, 1);
    applyStimulus(1, 0, 8'd0, 8'd0, 8'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      checkWave($sformatf("c603 k%0d", k), k < 3, k == 0);
      checkOutput($sformatf("c603 sticky k%0d", k), cfg_err, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
